// File: rtl/writeback_arbiter.sv
// Register-file writeback arbiter: ALU results have priority, load results wait in a
// DEPTH-entry FIFO, and a pending scoreboard tracks loads issued but not yet written back.
module writeback_arbiter #(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        alu_valid,
  input  logic [4:0]  alu_rd,
  input  logic [63:0] alu_data,
  output logic        alu_ready,
  input  logic        mem_valid,
  input  logic [4:0]  mem_rd,
  input  logic [63:0] mem_data,
  output logic        mem_ready,
  input  logic        issue_valid,
  input  logic [4:0]  issue_rd,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  output logic        rs1_pending,
  output logic        rs2_pending,
  output logic        RegWrite,
  output logic [4:0]  rd,
  output logic [63:0] WriteData
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  // Handshake: a result transfers on a rising edge where valid and ready are both 1;
  // ready depends only on registered state, never on the same-cycle valid.
  logic [4:0]    r_q_rd   [DEPTH];
  logic [63:0]   r_q_data [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic          r_active;
  logic [31:0]   r_pending;

  logic          w_not_full;
  logic          w_alu_wr;
  logic          w_push;
  logic          w_pop;
  logic [31:0]   w_pending_next;

  assign w_not_full = r_active && (r_count < CW'(DEPTH));
  assign alu_ready  = w_not_full;
  assign mem_ready  = w_not_full;

  // Destination-0 results are accepted but go nowhere.
  assign w_alu_wr = alu_valid && alu_ready && (alu_rd != 5'd0);
  assign w_push   = mem_valid && mem_ready && (mem_rd != 5'd0);
  assign w_pop    = !w_alu_wr && (r_count != '0);

  always_comb begin
    w_pending_next = r_pending;
    if (w_pop) w_pending_next[r_q_rd[r_rd_ptr]] = 1'b0;
    if (issue_valid && (issue_rd != 5'd0)) w_pending_next[issue_rd] = 1'b1;
    w_pending_next[0] = 1'b0;
  end

  assign rs1_pending = r_pending[rs1];
  assign rs2_pending = r_pending[rs2];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_active  <= 1'b0;
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_count   <= '0;
      r_pending <= '0;
      RegWrite  <= 1'b0;
      rd        <= 5'd0;
      WriteData <= 64'd0;
    end else begin
      r_active  <= 1'b1;
      r_pending <= w_pending_next;
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
      if (w_alu_wr) begin
        RegWrite  <= 1'b1;
        rd        <= alu_rd;
        WriteData <= alu_data;
      end else if (w_pop) begin
        RegWrite  <= 1'b1;
        rd        <= r_q_rd[r_rd_ptr];
        WriteData <= r_q_data[r_rd_ptr];
      end else begin
        RegWrite  <= 1'b0;
        rd        <= 5'd0;
        WriteData <= 64'd0;
      end
    end
  end

  // Storage needs no reset; only entries between the pointers are ever read.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_q_rd[r_wr_ptr]   <= mem_rd;
      r_q_data[r_wr_ptr] <= mem_data;
    end
  end

endmodule

// File: doc/writeback_arbiter.md
WRITEBACK_ARBITER -- requirements
Module: writeback_arbiter

Interface
REQ-001 SHALL have parameter DEPTH, default 4, load-result queue entries (power of two, 2..16).
REQ-002 SHALL have port clk  input  1  rising-edge clock, the only clock.
REQ-003 SHALL have port reset  input  1  asynchronous, active-low reset (0 = in reset).
REQ-004 SHALL have port alu_valid  input  1  ALU result offered this cycle.
REQ-005 SHALL have port alu_rd  input  5  ALU destination register.
REQ-006 SHALL have port alu_data  input  64  ALU result.
REQ-007 SHALL have port alu_ready  output  1  ALU result accepted when alu_valid and alu_ready are both 1.
REQ-008 SHALL have port mem_valid  input  1  load result offered this cycle.
REQ-009 SHALL have port mem_rd  input  5  load destination register.
REQ-010 SHALL have port mem_data  input  64  load data.
REQ-011 SHALL have port mem_ready  output  1  load result accepted when mem_valid and mem_ready are both 1.
REQ-012 SHALL have port issue_valid  input  1  load issued this cycle; marks issue_rd pending.
REQ-013 SHALL have port issue_rd  input  5  destination of the issued load.
REQ-014 SHALL have ports rs1, rs2  input  5 each  source registers queried for pending state.
REQ-015 SHALL have ports rs1_pending, rs2_pending  output  1 each  queried register awaits a load writeback.
REQ-016 SHALL have ports RegWrite  output  1, rd  output  5, WriteData  output  64  register-file write port.

Function
REQ-017 SHALL buffer accepted load results in a DEPTH-entry FIFO with count 0..DEPTH.
REQ-018 SHALL assert mem_ready exactly when count < DEPTH; simultaneous pop does not raise mem_ready in the same cycle.
REQ-019 SHALL assert alu_ready exactly when count < DEPTH; when the FIFO is full, the ALU is back-pressured so the FIFO drains.
REQ-020 SHALL select, per cycle: accepted ALU result with alu_rd != 0 first; otherwise the FIFO head if count > 0; otherwise none.
REQ-021 SHALL register the selection: RegWrite/rd/WriteData reflect it at the next rising edge, held exactly one cycle (latency 1).
REQ-022 SHALL drive RegWrite = 0, rd = 0, WriteData = 0 in cycles with no selection.
REQ-023 SHALL discard accepted results with destination 0: no write and no FIFO push; ALU drop frees that cycle for a FIFO pop.
REQ-024 SHALL, when full, pop the head in the same cycle as a blocked ALU offer (alu_ready = 0).
REQ-025 SHALL pop and push in the same cycle when both occur; count unchanged, order preserved.
REQ-026 SHALL keep a 32-bit pending vector; bit 0 is constant 0.
REQ-027 SHALL set pending[issue_rd] on issue_valid when issue_rd != 0.
REQ-028 SHALL clear pending[rd] on the edge where a FIFO-sourced write is registered to the outputs; ALU writes do not clear pending.
REQ-029 SHALL let set win when set and clear target the same register in the same cycle.
REQ-030 SHALL drive rs1_pending = pending[rs1] and rs2_pending = pending[rs2] combinationally from the registered vector.
REQ-031 SHALL not reorder or check WAW between ALU and queued loads; the issuer stalls on pending flags.

Reset
REQ-032 SHALL, while reset = 0, clear FIFO pointers and count, clear the pending vector, and drive RegWrite = 0, rd = 0, WriteData = 0, alu_ready = 0, mem_ready = 0.
REQ-033 SHALL drop in-flight queued results on reset mid-operation, with no write issued.
REQ-034 SHALL resume accepting on the first rising edge after reset returns to 1: alu_ready = mem_ready = 1.

Verification
REQ-035 ALU only: alu_valid, alu_rd = 5, alu_data = 64'h1234 at cycle N -> RegWrite = 1, rd = 5, WriteData = 64'h1234 during cycle N+1 only.
REQ-036 Priority: ALU (rd = 3, 64'hA) and queued load (rd = 7, 64'hB) same cycle -> rd 3 written at N+1, rd 7 at N+2.
REQ-037 Back-pressure: 4 loads queued, continuous ALU offers -> alu_ready = mem_ready = 0; head popped; readies return 1 next cycle.
REQ-038 Scoreboard: issue_rd = 9 -> rs1 = 9 shows rs1_pending = 1 until load rd 9 written; new issue to 9 on clear cycle -> stays 1.
REQ-039 Zero register: alu_rd = 0 and mem_rd = 0 offered -> no RegWrite, count unchanged, pending[0] stays 0.
REQ-040 Reset: reset low with 3 queued loads -> outputs 0, count 0, pending cleared; no write of the queued data after release.
